classify_seq: RTL and testbench
===============================

// Module: classify_seq
// PURPOSE
//  Sequencer for the classification output stage. It owns one classification frame of the
//  two-neuron spike counter (en_t / potential1_t / potential2_t):
//    - clears the counters, opens a spike window of WINDOW cycles, drains in-flight edges;
//    - reads both potentials and returns a class decision over a valid/ready handshake.
//  Sits between the top-level frame control and the output-neuron counter instance.
// PARAMETERS
//  WINDOW   64  en_t-high cycles per frame (>=1)
//  CNT_W    3   potential width, matches counter outputs
//  STOP_TH  6   early-stop threshold; must be <= 2**CNT_W-2 (one in-flight increment headroom)
//  FLUSH    2   drain cycles after en_t falls (counter pipeline depth)
// PORTS
//  clk           in   1      system clock
//  rst_n         in   1      asynchronous active-low reset
//  start         in   1      begin frame; sampled only in IDLE
//  abort         in   1      cancel frame in CLEAR/SETTLE/RUN/DRAIN, no result issued
//  busy          out  1      high in every state except IDLE
//  en_t          out  1      window enable to counter; high only in RUN
//  neuron_rst_n  out  1      counter clear, low exactly one cycle (CLEAR); flop-driven
//  potential1_t  in   CNT_W  class-0 spike count
//  potential2_t  in   CNT_W  class-1 spike count
//  result_valid  out  1      decision available; high in HOLD
//  result_ready  in   1      consumer accepts decision
//  class_id      out  1      0: class 0 wins or tie; 1: class 1 wins
//  tie           out  1      potentials equal at DECIDE
//  early_stop    out  1      window ended by STOP_TH, not by window counter
// BEHAVIOUR
//  - Clock and reset: one clock; reset is asynchronous and active-low.
//  - Reset state: state IDLE, busy=0, en_t=0, neuron_rst_n=1, result_valid=0, class_id=0,
//    tie=0, early_stop=0, window counter=0. Reset mid-frame returns immediately to IDLE.
//  - Outputs are registered (Moore); no combinational path from input to output.
//  - FSM, one step per clock:
//      IDLE  -start->  CLEAR -> SETTLE -> RUN -> DRAIN -> DECIDE -> HOLD -> IDLE
//  - CLEAR: neuron_rst_n=0 for one cycle. SETTLE: one idle cycle, en_t=0.
//  - RUN: en_t=1; window counter increments from 0.
//      Leaves to DRAIN when count==WINDOW-1 or max(potential1_t,potential2_t)>=STOP_TH.
//      early_stop is latched 1 only if the threshold condition is true on the exit cycle,
//      including when it coincides with window expiry.
//  - DRAIN: FLUSH cycles with en_t=0; potentials may still increment by at most 1 each.
//  - DECIDE: unsigned compare of the potentials.
//      class_id=(p2>p1); tie=(p1==p2). class_id, tie and early_stop are registered here.
//  - HOLD: result_valid=1.
//      class_id, tie and early_stop stay stable until result_ready=1.
//      On the ready cycle go to IDLE; result_valid drops next cycle.
//      class_id, tie and early_stop hold their values until the next DECIDE.
//  - Latency: the edge sampling start in IDLE is edge 0.
//      Without early stop, result_valid rises WINDOW+FLUSH+3 cycles after edge 0.
//  - start: ignored while busy; start held high re-triggers from IDLE the cycle after HOLD exits.
//  - abort: abort=1 in CLEAR/SETTLE/RUN/DRAIN goes to IDLE next cycle; en_t drops,
//    no result_valid. Ignored in IDLE, DECIDE and HOLD. abort and start together in IDLE:
//    start wins.
//  - The potentials never wrap during a frame because STOP_TH <= 2**CNT_W-2.
// STRUCTURE
//  - Shared include classify_defs.vh:
//      state encodings (3-bit: IDLE, CLEAR, SETTLE, RUN, DRAIN, DECIDE, HOLD);
//      CNT_W default; STOP_TH legality check macro.
//  - One sub-module: classify_argmax (combinational compare of two CNT_W values -> class_id, tie).
//  - Window and drain counters are a single shared counter, $clog2(WINDOW+1) bits, reloaded per state.
// TESTING (WINDOW=8, FLUSH=2, STOP_TH=6, CNT_W=3)
//  1. Reset with start=1 -> all outputs at reset values; after release, first start accepted
//     one cycle later.
//  2. start pulse, 3 spikes on neuron 1, 1 on neuron 2 -> en_t high exactly 8 cycles;
//     neuron_rst_n low 1 cycle; result_valid rises 13 cycles after start edge;
//     class_id=0, tie=0, early_stop=0.
//  3. Continuous spiking on neuron 2 reaching 6 -> en_t falls the cycle after p2=6;
//     final p2<=7; class_id=1, early_stop=1.
//  4. Equal counts 2/2 -> tie=1, class_id=0.
//  5. result_ready held 0 for 10 cycles -> result_valid and result fields stable throughout;
//     start pulses in that interval ignored; ready=1 -> IDLE.
//  6. abort in RUN cycle 3 -> en_t=0 and busy=0 next cycle, no result_valid;
//     new start completes normally with counters cleared. Async reset asserted in DRAIN
//     -> IDLE immediately.

Source files
------------

// File: rtl/classify_seq_pkg.sv
// ============================================================================
// classify_seq_pkg : shared state encodings, types and parameter helpers
// Revision 1.0
// ============================================================================
`default_nettype none

package classify_seq_pkg;

   localparam int CNT_W_DEF = 3;

   localparam logic [2:0] ST_IDLE   = 3'd0;
   localparam logic [2:0] ST_CLEAR  = 3'd1;
   localparam logic [2:0] ST_SETTLE = 3'd2;
   localparam logic [2:0] ST_RUN    = 3'd3;
   localparam logic [2:0] ST_DRAIN  = 3'd4;
   localparam logic [2:0] ST_DECIDE = 3'd5;
   localparam logic [2:0] ST_HOLD   = 3'd6;

   typedef struct packed {
      logic class_id;
      logic tie;
   } decision_t;

   // The threshold must leave room for one in-flight increment without wrapping.
   function automatic bit stop_th_ok(input int stop_th, input int cnt_w);
      return stop_th <= (1 << cnt_w) - 2;
   endfunction

endpackage

`default_nettype wire

// File: rtl/classify_argmax.sv
// ============================================================================
// classify_argmax : combinational compare of two potentials -> class, tie
// Revision 1.0
// ============================================================================
`default_nettype none

module classify_argmax
   import classify_seq_pkg::*;
#(
   parameter int CNT_W = CNT_W_DEF
) (
   input  logic [CNT_W-1:0] p1,
   input  logic [CNT_W-1:0] p2,
   output decision_t        dec
);

   assign dec.class_id = (p2 > p1);
   assign dec.tie      = (p1 == p2);

endmodule

`default_nettype wire

// File: rtl/classify_seq.sv
// ============================================================================
// classify_seq : frame sequencer for the two-neuron classification stage
// Revision 1.0
// ============================================================================
`default_nettype none

module classify_seq
   import classify_seq_pkg::*;
#(
   parameter int WINDOW  = 64,
   parameter int CNT_W   = CNT_W_DEF,
   parameter int STOP_TH = 6,
   parameter int FLUSH   = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             abort,
   output logic             busy,
   output logic             en_t,
   output logic             neuron_rst_n,
   input  logic [CNT_W-1:0] potential1_t,
   input  logic [CNT_W-1:0] potential2_t,
   output logic             result_valid,
   input  logic             result_ready,
   output logic             class_id,
   output logic             tie,
   output logic             early_stop
);

   localparam int              CW        = $clog2(WINDOW + 1);
   localparam logic [CW-1:0]   WIN_LAST  = CW'(WINDOW - 1);
   localparam logic [CW-1:0]   FLUSH_END = CW'(FLUSH - 1);
   localparam logic [CNT_W-1:0] TH       = CNT_W'(STOP_TH);

   if (!stop_th_ok(STOP_TH, CNT_W)) begin : g_bad_stop_th
      $error("classify_seq: STOP_TH exceeds 2**CNT_W-2");
   end

   logic [2:0]       state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             stop_flag_q, stop_flag_d;
   logic             busy_q, busy_d;
   logic             en_t_q, en_t_d;
   logic             nrst_q, nrst_d;
   logic             valid_q, valid_d;
   logic             class_q, class_d;
   logic             tie_q, tie_d;
   logic             early_q, early_d;
   logic [CNT_W-1:0] pmax;
   logic             thr_hit;
   decision_t        dec;

   classify_argmax #(.CNT_W(CNT_W)) u_argmax (
      .p1  (potential1_t),
      .p2  (potential2_t),
      .dec (dec)
   );

   assign pmax    = (potential1_t > potential2_t) ? potential1_t : potential2_t;
   assign thr_hit = (pmax >= TH);

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      stop_flag_d = stop_flag_q;
      class_d     = class_q;
      tie_d       = tie_q;
      early_d     = early_q;
      case (state_q)
         ST_IDLE:   if (start) state_d = ST_CLEAR;
         ST_CLEAR:  state_d = abort ? ST_IDLE : ST_SETTLE;
         ST_SETTLE: begin
            state_d = abort ? ST_IDLE : ST_RUN;
            cnt_d   = '0;
         end
         ST_RUN: begin
            if (abort) begin
               state_d = ST_IDLE;
            end else if (thr_hit || cnt_q == WIN_LAST) begin
               // Threshold wins the early_stop flag even on the window's last cycle.
               state_d     = ST_DRAIN;
               cnt_d       = '0;
               stop_flag_d = thr_hit;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         ST_DRAIN: begin
            if (abort) begin
               state_d = ST_IDLE;
            end else if (cnt_q == FLUSH_END) begin
               state_d = ST_DECIDE;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         ST_DECIDE: begin
            state_d = ST_HOLD;
            class_d = dec.class_id;
            tie_d   = dec.tie;
            early_d = stop_flag_q;
         end
         ST_HOLD:   if (result_ready) state_d = ST_IDLE;
         default:   state_d = ST_IDLE;
      endcase
      if (state_d == ST_IDLE) cnt_d = '0;

      // Outputs are registered from the next state so they line up with it.
      busy_d  = (state_d != ST_IDLE);
      en_t_d  = (state_d == ST_RUN);
      nrst_d  = (state_d != ST_CLEAR);
      valid_d = (state_d == ST_HOLD);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         cnt_q       <= '0;
         stop_flag_q <= 1'b0;
         busy_q      <= 1'b0;
         en_t_q      <= 1'b0;
         nrst_q      <= 1'b1;
         valid_q     <= 1'b0;
         class_q     <= 1'b0;
         tie_q       <= 1'b0;
         early_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         stop_flag_q <= stop_flag_d;
         busy_q      <= busy_d;
         en_t_q      <= en_t_d;
         nrst_q      <= nrst_d;
         valid_q     <= valid_d;
         class_q     <= class_d;
         tie_q       <= tie_d;
         early_q     <= early_d;
      end
   end

   assign busy         = busy_q;
   assign en_t         = en_t_q;
   assign neuron_rst_n = nrst_q;
   assign result_valid = valid_q;
   assign class_id     = class_q;
   assign tie          = tie_q;
   assign early_stop   = early_q;

endmodule

`default_nettype wire

// File: tb/tb_classify_seq.sv
// ============================================================================
// tb_classify_seq : self-checking bench for classify_seq (WINDOW=8, FLUSH=2)
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_classify_seq;

   localparam int W  = 8;
   localparam int FL = 2;
   localparam int TH = 6;
   localparam int CN = 3;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          start;
   logic          abort;
   logic          result_ready;
   logic          busy, en_t, neuron_rst_n, result_valid, class_id, tie, early_stop;
   logic [CN-1:0] p1, p2;

   int checks = 0;
   int errors = 0;

   classify_seq #(.WINDOW(W), .CNT_W(CN), .STOP_TH(TH), .FLUSH(FL)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .start        (start),
      .abort        (abort),
      .busy         (busy),
      .en_t         (en_t),
      .neuron_rst_n (neuron_rst_n),
      .potential1_t (p1),
      .potential2_t (p2),
      .result_valid (result_valid),
      .result_ready (result_ready),
      .class_id     (class_id),
      .tie          (tie),
      .early_stop   (early_stop)
   );

   always #5 clk = ~clk;

   // Spike-counter stand-in: bit k of each pattern is a spike in the k-th en_t cycle.
   logic [W-1:0] pat1, pat2;
   int           idx;
   always @(posedge clk) begin
      if (!neuron_rst_n) begin
         p1  <= '0;
         p2  <= '0;
         idx <= 0;
      end else if (en_t) begin
         if (idx < W) begin
            p1 <= p1 + {{(CN-1){1'b0}}, pat1[idx]};
            p2 <= p2 + {{(CN-1){1'b0}}, pat2[idx]};
         end
         idx <= idx + 1;
      end
   end

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Frame outcome straight from the rules: window ends at the first cycle whose
   // incoming potentials reach the threshold, or at the last window cycle.
   function automatic void ref_frame(input logic [W-1:0] a, input logic [W-1:0] b,
                                     output logic cls, output logic tq,
                                     output logic early, output int en);
      int  s1, s2;
      bit  thr;
      s1 = 0; s2 = 0; en = W; early = 1'b0;
      for (int k = 0; k < W; k++) begin
         thr = (s1 >= TH) || (s2 >= TH);
         s1 += int'(a[k]);
         s2 += int'(b[k]);
         if (thr || k == W - 1) begin
            early = thr;
            en    = k + 1;
            break;
         end
      end
      cls = (s2 > s1);
      tq  = (s1 == s2);
   endfunction

   task automatic run_frame(input logic [W-1:0] a, input logic [W-1:0] b,
                            input logic ecls, input logic etie, input logic eearly,
                            input int een, input int hold_cycles, input string tag);
      int lat, en_cnt, nr_cnt;
      bit got, stable;
      pat1 = a;
      pat2 = b;
      @(negedge clk);
      start = 1'b1;
      @(posedge clk);
      #1;
      start  = 1'b0;
      lat    = 0;
      en_cnt = 0;
      nr_cnt = neuron_rst_n ? 0 : 1;
      got    = 1'b0;
      for (int i = 0; i < 200 && !got; i++) begin
         @(posedge clk);
         #1;
         lat++;
         if (en_t) en_cnt++;
         if (!neuron_rst_n) nr_cnt++;
         if (result_valid) got = 1'b1;
      end
      chk({tag, " valid_seen"}, int'(got), 1);
      chk({tag, " latency"}, lat, een + FL + 3);
      chk({tag, " en_cycles"}, en_cnt, een);
      chk({tag, " nrst_low_cycles"}, nr_cnt, 1);
      chk({tag, " class_id"}, int'(class_id), int'(ecls));
      chk({tag, " tie"}, int'(tie), int'(etie));
      chk({tag, " early_stop"}, int'(early_stop), int'(eearly));
      stable = 1'b1;
      for (int i = 0; i < hold_cycles; i++) begin
         @(negedge clk);
         start = i[0];
         @(posedge clk);
         #1;
         if (!result_valid || !busy || class_id !== ecls || tie !== etie || early_stop !== eearly)
            stable = 1'b0;
      end
      if (hold_cycles > 0) chk({tag, " hold_stable"}, int'(stable), 1);
      @(negedge clk);
      start        = 1'b0;
      result_ready = 1'b1;
      @(posedge clk);
      #1;
      result_ready = 1'b0;
      chk({tag, " valid_drop"}, int'(result_valid), 0);
      chk({tag, " idle_after"}, int'(busy), 0);
   endtask

   typedef struct {
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic         cls;
      logic         tq;
      logic         early;
      int           en;
   } vec_t;

   vec_t tbl[5];

   initial begin
      logic   rc, rt, re;
      int     ren;
      bit     seen;
      logic [W-1:0] ra, rb;

      tbl[0] = '{a: 8'b0000_0111, b: 8'b0000_0001, cls: 1'b0, tq: 1'b0, early: 1'b0, en: 8};
      tbl[1] = '{a: 8'b0000_0000, b: 8'b1111_1111, cls: 1'b1, tq: 1'b0, early: 1'b1, en: 7};
      tbl[2] = '{a: 8'b0000_0011, b: 8'b0000_1100, cls: 1'b0, tq: 1'b1, early: 1'b0, en: 8};
      tbl[3] = '{a: 8'b1111_1111, b: 8'b1111_1111, cls: 1'b0, tq: 1'b1, early: 1'b1, en: 7};
      tbl[4] = '{a: 8'b0111_1110, b: 8'b0000_0000, cls: 1'b0, tq: 1'b0, early: 1'b1, en: 8};

      // Reset held with start high
      rst_n = 1'b0; start = 1'b1; abort = 1'b0; result_ready = 1'b0;
      pat1 = '0; pat2 = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst busy", int'(busy), 0);
      chk("rst en_t", int'(en_t), 0);
      chk("rst neuron_rst_n", int'(neuron_rst_n), 1);
      chk("rst result_valid", int'(result_valid), 0);
      chk("rst class_id", int'(class_id), 0);
      chk("rst tie", int'(tie), 0);
      chk("rst early_stop", int'(early_stop), 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      chk("first start busy", int'(busy), 1);
      chk("first start nrst", int'(neuron_rst_n), 0);
      seen = 1'b0;
      for (int i = 0; i < 100 && !seen; i++) begin
         @(posedge clk);
         #1;
         if (result_valid) seen = 1'b1;
      end
      chk("first frame valid", int'(seen), 1);
      chk("first frame tie", int'(tie), 1);
      @(negedge clk);
      result_ready = 1'b1;
      @(posedge clk);
      #1;
      result_ready = 1'b0;

      // Table-driven frames; the tie frame also exercises a long ready stall
      for (int t = 0; t < 5; t++) begin
         run_frame(tbl[t].a, tbl[t].b, tbl[t].cls, tbl[t].tq, tbl[t].early, tbl[t].en,
                   (t == 2) ? 10 : 0, $sformatf("vec%0d", t));
      end

      // Abort in RUN cycle 3
      pat1 = tbl[0].a; pat2 = tbl[0].b;
      @(negedge clk);
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      chk("abort pre en_t", int'(en_t), 1);
      @(negedge clk);
      abort = 1'b1;
      @(posedge clk);
      #1;
      abort = 1'b0;
      chk("abort en_t", int'(en_t), 0);
      chk("abort busy", int'(busy), 0);
      seen = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(posedge clk);
         #1;
         if (result_valid || busy) seen = 1'b1;
      end
      chk("abort no result", int'(seen), 0);
      run_frame(tbl[0].a, tbl[0].b, 1'b0, 1'b0, 1'b0, 8, 0, "post_abort");

      // Leave class_id/early_stop set, then reset asynchronously in DRAIN
      run_frame(tbl[1].a, tbl[1].b, 1'b1, 1'b0, 1'b1, 7, 0, "pre_reset");
      pat1 = tbl[0].a; pat2 = tbl[0].b;
      @(negedge clk);
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (10) @(posedge clk);
      #2;
      chk("drain en_t", int'(en_t), 0);
      chk("drain busy", int'(busy), 1);
      rst_n = 1'b0;
      #1;
      chk("async rst busy", int'(busy), 0);
      chk("async rst class_id", int'(class_id), 0);
      chk("async rst early_stop", int'(early_stop), 0);
      chk("async rst nrst", int'(neuron_rst_n), 1);
      @(negedge clk);
      rst_n = 1'b1;
      run_frame(tbl[2].a, tbl[2].b, 1'b0, 1'b1, 1'b0, 8, 0, "post_reset");

      // Randomized frames against the reference model
      for (int r = 0; r < 25; r++) begin
         case ($urandom_range(0, 3))
            0:       begin ra = W'($urandom); rb = W'($urandom); end
            1:       begin ra = W'($urandom & $urandom); rb = W'($urandom | $urandom); end
            2:       begin ra = W'($urandom | $urandom); rb = W'($urandom & $urandom); end
            default: begin ra = W'($urandom | $urandom); rb = W'($urandom | $urandom); end
         endcase
         ref_frame(ra, rb, rc, rt, re, ren);
         run_frame(ra, rb, rc, rt, re, ren, $urandom_range(0, 3), $sformatf("rnd%0d", r));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
